reg_file_pipe: RTL

REG_FILE_PIPE -- requirements
Module: reg_file_pipe

---
 rtl/reg_file_pkg.sv | 33 +++
 rtl/reg_file_pipe_dfrl_n.sv | 32 +++
 rtl/reg_file_pipe.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
//
// Purpose : Shared constants and helpers for the pipelined register file.
//           Holds the default geometry (WIDTH / DEPTH) and a clog2-style
//           address-width function. The register file and anything that
//           binds to it import this package so the geometry is defined once.
//
// Contents:
//   DEFAULT_WIDTH  - default data word width in bits
//   DEFAULT_DEPTH  - default number of registers
//   addr_width()   - number of address bits needed to index 'depth' entries
//                    (minimum 1, so a 2-entry file still gets a 1-bit address)
// ---------------------------------------------------------------------------
package reg_file_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    // Ceiling log2 written as a bounded loop so it elaborates the same way in
    // every tool. The result is clamped to at least one bit.
    function automatic int addr_width(input int depth);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/reg_file_pipe_dfrl_n.sv
// ---------------------------------------------------------------------------
// dfrl_n
//
// Purpose : WIDTH-bit storage register with synchronous active-high reset and
//           a load enable. One instance holds one register-file entry.
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous reset; clears q, overrides load
//   load   in   1      capture d on the next rising edge
//   d      in   WIDTH  data to capture
//   q      out  WIDTH  stored value
// ---------------------------------------------------------------------------
module dfrl_n #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file_pipe.sv
// ---------------------------------------------------------------------------
// reg_file_pipe
//
// Purpose : DEPTH x WIDTH register file with one write port and two fully
//           independent registered read ports (A and B), write-first read
//           bypass, optional hard-wired zero register, and per-register
//           "written since last clear" dirty flags.
//
// Ports:
//   clk        in   1      rising-edge clock, all state changes here
//   reset      in   1      synchronous active-high reset; clears storage,
//                          dirty flags and both read outputs, and drops any
//                          write / read / clear request in the same cycle
//   wr         in   1      write enable
//   wr_addr    in   AW     write address
//   d_in       in   WIDTH  write data
//   rd_en_a    in   1      read request, port A
//   rd_addr_a  in   AW     read address, port A
//   rd_en_b    in   1      read request, port B
//   rd_addr_b  in   AW     read address, port B
//   d_out_a    out  WIDTH  registered read data, port A
//   d_out_b    out  WIDTH  registered read data, port B
//   vld_a      out  1      read data valid, port A
//   vld_b      out  1      read data valid, port B
//   clr_dirty  in   1      clear every dirty flag
//   dirty      out  DEPTH  bit i set = register i written since last clear
//
// Read handshake: there is no back-pressure. A read port sampled with
// rd_en_x=1 at edge N presents the data on d_out_x with vld_x=1 for exactly
// the cycle following edge N. When rd_en_x=0 at an edge, vld_x drops to 0
// and d_out_x keeps its previous value. Reads can be issued every cycle.
// ---------------------------------------------------------------------------
module reg_file_pipe
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int ZERO_REG = 0,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] d_in,
    input  logic             rd_en_a,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic             rd_en_b,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] d_out_a,
    output logic [WIDTH-1:0] d_out_b,
    output logic             vld_a,
    output logic             vld_b,
    input  logic             clr_dirty,
    output logic [DEPTH-1:0] dirty
);

    // -----------------------------------------------------------------------
    // Decode: one-hot write strobes and read selects, one bit per register.
    // Register 0 is masked out of every strobe when it is the zero register,
    // so a write to it is discarded, never marks it dirty, never bypasses,
    // and a read of it returns all zeros through the empty select.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] sel_a;
    logic [DEPTH-1:0] sel_b;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == 0);

            if (IS_ZERO) begin : g_zero
                assign load[gi]  = 1'b0;
                assign sel_a[gi] = 1'b0;
                assign sel_b[gi] = 1'b0;
            end else begin : g_normal
                assign load[gi]  = wr && (wr_addr == AW'(gi));
                assign sel_a[gi] = (rd_addr_a == AW'(gi));
                assign sel_b[gi] = (rd_addr_b == AW'(gi));
            end

            dfrl_n #(
                .WIDTH (WIDTH)
            ) u_reg (
                .clk   (clk),
                .reset (reset),
                .load  (load[gi]),
                .d     (d_in),
                .q     (regs[gi])
            );

            // Set wins over clear: a write landing in the same cycle as
            // clr_dirty leaves its own flag at 1.
            always_ff @(posedge clk) begin
                if (reset) begin
                    dirty[gi] <= 1'b0;
                end else begin
                    dirty[gi] <= load[gi] | (dirty[gi] & ~clr_dirty);
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read select: AND-OR mux over the one-hot selects. A write to the same
    // entry in the same cycle is forwarded (write-first), which is exactly
    // "load[i] & sel[i]" since both are already zero-register masked.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic             bypass_a;
    logic             bypass_b;

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_data_a = rd_data_a | ({WIDTH{sel_a[i]}} & regs[i]);
            rd_data_b = rd_data_b | ({WIDTH{sel_b[i]}} & regs[i]);
        end
    end

    assign bypass_a = |(load & sel_a);
    assign bypass_b = |(load & sel_b);

    // -----------------------------------------------------------------------
    // Registered read outputs. Data only updates on a request so the last
    // value is held while a port is idle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            d_out_a <= '0;
            d_out_b <= '0;
            vld_a   <= 1'b0;
            vld_b   <= 1'b0;
        end else begin
            vld_a <= rd_en_a;
            vld_b <= rd_en_b;
            if (rd_en_a) begin
                d_out_a <= bypass_a ? d_in : rd_data_a;
            end
            if (rd_en_b) begin
                d_out_b <= bypass_b ? d_in : rd_data_b;
            end
        end
    end

endmodule
